// File: rtl/impairment_sweep_ctrl.sv
// Jitter-scale sweep sequencer: steps the impairment model through a programmed
// scale table, holding each entry for a settle window and then a measurement window.
module impairment_sweep_ctrl #(
  parameter int NUM_STEPS  = 8,
  parameter int SCALE_W    = 16,
  parameter int CNT_W      = 24,
  parameter int SETTLE_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [$clog2(NUM_STEPS):0]   step_count,
  input  logic [CNT_W-1:0]             meas_len,
  input  logic                         tbl_wr_en,
  input  logic [$clog2(NUM_STEPS)-1:0] tbl_wr_addr,
  input  logic [SCALE_W-1:0]           tbl_wr_data,
  input  logic                         sample_valid,
  output logic [SCALE_W-1:0]           jit_scale,
  output logic                         jit_en,
  output logic                         meas_clr,
  output logic                         meas_en,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx,
  output logic                         step_done,
  output logic                         busy,
  output logic                         done,
  output logic                         aborted
);
  localparam int IDX_W = $clog2(NUM_STEPS);
  localparam int NUM_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);
  localparam logic [NUM_W-1:0] MAX_STEPS = NUM_W'(NUM_STEPS);

  if (SETTLE_CYC < 0 || 64'(SETTLE_CYC) > ((64'd1 << CNT_W) - 64'd1)) begin : g_settle_range
    $error("SETTLE_CYC does not fit in CNT_W bits");
  end

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, MEASURE, NEXT} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     len_q, len_d;
  logic [NUM_W-1:0]     num_q, num_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SCALE_W-1:0]   scale_q, scale_d;
  logic                 jen_q, jen_d;
  logic                 clr_q, clr_d;
  logic                 done_q, done_d;
  logic                 abt_q, abt_d;
  logic [SCALE_W-1:0]   tbl_q [NUM_STEPS];

  // Table is host-owned storage; it is only writable while no sweep is running.
  always_ff @(posedge clk) begin
    if (tbl_wr_en && state_q == IDLE) begin
      tbl_q[tbl_wr_addr] <= tbl_wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    num_d   = num_q;
    idx_d   = idx_q;
    scale_d = scale_q;
    jen_d   = jen_q;
    clr_d   = 1'b0;
    done_d  = 1'b0;
    abt_d   = 1'b0;
    if (state_q != IDLE && abort) begin
      // step_idx deliberately holds so the host can see where the sweep stopped
      state_d = IDLE;
      jen_d   = 1'b0;
      scale_d = '0;
      abt_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            if (step_count == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = LOAD;
              idx_d   = '0;
              num_d   = (step_count > MAX_STEPS) ? MAX_STEPS : step_count;
              len_d   = (meas_len == '0) ? CNT_W'(1) : meas_len;
            end
          end
        end
        LOAD: begin
          scale_d = tbl_q[idx_q];
          jen_d   = 1'b1;
          if (SETTLE_LD == '0) begin
            state_d = MEASURE;
            cnt_d   = len_q;
            clr_d   = 1'b1;
          end else begin
            state_d = SETTLE;
            cnt_d   = SETTLE_LD;
          end
        end
        SETTLE: begin
          if (sample_valid) begin
            if (cnt_q == CNT_W'(1)) begin
              state_d = MEASURE;
              cnt_d   = len_q;
              clr_d   = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        MEASURE: begin
          if (sample_valid) begin
            if (cnt_q == CNT_W'(1)) begin
              state_d = NEXT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        NEXT: begin
          if ({1'b0, idx_q} == num_q - NUM_W'(1)) begin
            state_d = IDLE;
            jen_d   = 1'b0;
            scale_d = '0;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      scale_q <= '0;
      jen_q   <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      scale_q <= scale_d;
      jen_q   <= jen_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      abt_q   <= abt_d;
    end
  end

  assign jit_scale = scale_q;
  assign jit_en    = jen_q;
  assign meas_clr  = clr_q;
  assign meas_en   = (state_q == MEASURE);
  assign step_idx  = idx_q;
  assign step_done = (state_q == NEXT);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign aborted   = abt_q;

endmodule

// File: tb/tb_impairment_sweep_ctrl.sv
// Bench for impairment_sweep_ctrl: two builds (settle 16 and settle 0) share one
// stimulus stream; each is checked every cycle against a strobe-counting model.
`timescale 1ns/1ps
module tb_impairment_sweep_ctrl;
  localparam int NS = 8;
  localparam int SW = 16;
  localparam int CW = 24;
  localparam int IW = $clog2(NS);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0, abort = 1'b0, tbl_wr_en = 1'b0, sample_valid = 1'b0;
  logic [IW:0]   step_count = '0;
  logic [CW-1:0] meas_len = '0;
  logic [IW-1:0] tbl_wr_addr = '0;
  logic [SW-1:0] tbl_wr_data = '0;

  int checks = 0;
  int errors = 0;
  int sv_mode = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL u%0d.%s got %0h expected %0h at %0t", g, nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    cyc++;
    case (sv_mode)
      1:       sample_valid = (cyc % 4 == 0);
      2:       sample_valid = ($urandom_range(2) == 0);
      default: sample_valid = 1'b0;
    endcase
  end

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int S = (g == 0) ? 16 : 0;
    logic [SW-1:0] jit_scale;
    logic          jit_en, meas_clr, meas_en, step_done, busy, done, aborted;
    logic [IW-1:0] step_idx;

    impairment_sweep_ctrl #(.NUM_STEPS(NS), .SCALE_W(SW), .CNT_W(CW), .SETTLE_CYC(S)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .step_count(step_count), .meas_len(meas_len),
      .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
      .sample_valid(sample_valid), .jit_scale(jit_scale), .jit_en(jit_en),
      .meas_clr(meas_clr), .meas_en(meas_en), .step_idx(step_idx),
      .step_done(step_done), .busy(busy), .done(done), .aborted(aborted));

    // Model: phase 0 idle, 1 load gap, 2 step body (settle then window), 3 step gap.
    // Within the body the position is the total strobes seen since the load.
    bit [SW-1:0] tbl [NS];
    int ph = 0, m_step = 0, m_n = 0, m_len = 0, m_seen = 0;
    bit [SW-1:0] e_scale = '0;
    bit e_jen = 0, e_clr = 0, e_done = 0, e_abt = 0;

    initial for (int i = 0; i < NS; i++) tbl[i] = '0;

    always @(posedge clk or posedge reset) begin
      if (reset) begin
        ph = 0; m_step = 0; m_n = 0; m_len = 0; m_seen = 0;
        e_scale = '0; e_jen = 0; e_clr = 0; e_done = 0; e_abt = 0;
      end else begin
        e_clr = 0; e_done = 0; e_abt = 0;
        if (tbl_wr_en && ph == 0) tbl[tbl_wr_addr] = tbl_wr_data;
        if (ph == 0) begin
          if (start && !abort) begin
            m_n = (int'(step_count) > NS) ? NS : int'(step_count);
            if (m_n == 0) e_done = 1;
            else begin
              ph = 1; m_step = 0;
              m_len = (meas_len == 0) ? 1 : int'(meas_len);
            end
          end
        end else if (abort) begin
          ph = 0; e_jen = 0; e_scale = '0; e_abt = 1;
        end else if (ph == 1) begin
          e_scale = tbl[m_step]; e_jen = 1; ph = 2; m_seen = 0;
          if (S == 0) e_clr = 1;
        end else if (ph == 2) begin
          if (sample_valid) begin
            m_seen++;
            if (m_seen == S) e_clr = 1;
            if (m_seen == S + m_len) ph = 3;
          end
        end else begin
          if (m_step == m_n - 1) begin
            ph = 0; e_jen = 0; e_scale = '0; e_done = 1;
          end else begin
            m_step++; ph = 1;
          end
        end
      end
    end

    int n_sd = 0, n_done = 0, n_abt = 0, n_clr = 0, n_ms = 0, n_ms_step = 0, n_busy = 0, n_jen = 0;
    int sc [256];

    always @(negedge clk) begin
      chk("busy", g, busy, ph != 0);
      chk("jit_en", g, jit_en, e_jen);
      chk("jit_scale", g, jit_scale, e_scale);
      chk("meas_clr", g, meas_clr, e_clr);
      chk("meas_en", g, meas_en, (ph == 2) && (m_seen >= S));
      chk("step_done", g, step_done, ph == 3);
      chk("step_idx", g, step_idx, m_step);
      chk("done", g, done, e_done);
      chk("aborted", g, aborted, e_abt);
      if (step_done) begin sc[n_sd % 256] = int'(jit_scale); n_sd++; end
      n_done += int'(done); n_abt += int'(aborted); n_clr += int'(meas_clr);
      n_busy += int'(busy); n_jen += int'(jit_en);
      if (meas_clr) n_ms_step = 0;
      if (meas_en && sample_valid) begin n_ms++; n_ms_step++; end
    end
  end

  int b_sd[2], b_dn[2], b_ab[2], b_clr[2], b_ms[2], b_busy[2], b_jen[2];

  task automatic snap();
    b_sd[0] = u[0].n_sd;     b_sd[1] = u[1].n_sd;
    b_dn[0] = u[0].n_done;   b_dn[1] = u[1].n_done;
    b_ab[0] = u[0].n_abt;    b_ab[1] = u[1].n_abt;
    b_clr[0] = u[0].n_clr;   b_clr[1] = u[1].n_clr;
    b_ms[0] = u[0].n_ms;     b_ms[1] = u[1].n_ms;
    b_busy[0] = u[0].n_busy; b_busy[1] = u[1].n_busy;
    b_jen[0] = u[0].n_jen;   b_jen[1] = u[1].n_jen;
  endtask

  task automatic lits(input string t, input int sd, input int dn, input int ab);
    chk({t, ".step_done_cnt"}, 0, u[0].n_sd - b_sd[0], sd);
    chk({t, ".step_done_cnt"}, 1, u[1].n_sd - b_sd[1], sd);
    chk({t, ".done_cnt"}, 0, u[0].n_done - b_dn[0], dn);
    chk({t, ".done_cnt"}, 1, u[1].n_done - b_dn[1], dn);
    chk({t, ".aborted_cnt"}, 0, u[0].n_abt - b_ab[0], ab);
    chk({t, ".aborted_cnt"}, 1, u[1].n_abt - b_ab[1], ab);
  endtask

  task automatic zero_chk(input string t);
    chk({t, ".busy"}, 0, u[0].busy, 0);         chk({t, ".busy"}, 1, u[1].busy, 0);
    chk({t, ".jit_en"}, 0, u[0].jit_en, 0);     chk({t, ".jit_en"}, 1, u[1].jit_en, 0);
    chk({t, ".jit_scale"}, 0, u[0].jit_scale, 0); chk({t, ".jit_scale"}, 1, u[1].jit_scale, 0);
    chk({t, ".meas_en"}, 0, u[0].meas_en, 0);   chk({t, ".meas_en"}, 1, u[1].meas_en, 0);
    chk({t, ".step_idx"}, 0, u[0].step_idx, 0); chk({t, ".step_idx"}, 1, u[1].step_idx, 0);
    chk({t, ".pulses"}, 0, {u[0].done, u[0].aborted, u[0].step_done, u[0].meas_clr}, 0);
    chk({t, ".pulses"}, 1, {u[1].done, u[1].aborted, u[1].step_done, u[1].meas_clr}, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int a, input int d);
    tbl_wr_en = 1'b1; tbl_wr_addr = IW'(a); tbl_wr_data = SW'(d);
    tick();
    tbl_wr_en = 1'b0;
  endtask

  task automatic go(input int n, input int len);
    step_count = (IW + 1)'(n); meas_len = CW'(len); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string t, input int budget);
    int k = 0;
    while ((u[0].busy || u[1].busy) && k < budget) begin tick(); k++; end
    chk({t, ".finish_in_budget"}, 0, k < budget, 1);
    repeat (2) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t1v[3];
    int k;
    t1v[0] = 'h0000; t1v[1] = 'h0A3D; t1v[2] = 'h147B;
    #1 reset = 1'b1;
    repeat (3) tick();
    zero_chk("reset");
    reset = 1'b0;
    tick();

    wr(0, 'h0000); wr(1, 'h0A3D); wr(2, 'h147B);
    for (int i = 3; i < NS; i++) wr(i, int'($urandom_range(65535)));

    // Three-entry sweep, strobe every 4th cycle
    sv_mode = 1;
    snap(); go(3, 100); wait_idle("t1", 5000);
    lits("t1", 3, 1, 0);
    chk("t1.meas_clr_cnt", 0, u[0].n_clr - b_clr[0], 3); chk("t1.meas_clr_cnt", 1, u[1].n_clr - b_clr[1], 3);
    chk("t1.window_strobes", 0, u[0].n_ms - b_ms[0], 300); chk("t1.window_strobes", 1, u[1].n_ms - b_ms[1], 300);
    for (int i = 0; i < 3; i++) begin
      chk("t1.scale", 0, u[0].sc[(b_sd[0] + i) % 256], t1v[i]);
      chk("t1.scale", 1, u[1].sc[(b_sd[1] + i) % 256], t1v[i]);
    end
    chk("t1.jit_en_after", 0, u[0].jit_en, 0); chk("t1.jit_scale_after", 0, u[0].jit_scale, 0);

    // Empty sweep
    snap(); go(0, 5);
    chk("t2.done_next", 0, u[0].done, 1); chk("t2.done_next", 1, u[1].done, 1);
    repeat (3) tick();
    lits("t2", 0, 1, 0);
    chk("t2.busy_cycles", 0, u[0].n_busy - b_busy[0], 0); chk("t2.jit_en_cycles", 0, u[0].n_jen - b_jen[0], 0);
    chk("t2.window_strobes", 1, u[1].n_ms - b_ms[1], 0);

    // Oversized step count clamps to table depth
    sv_mode = 2;
    snap(); go(12, 5); wait_idle("t3", 20000);
    lits("t3", 8, 1, 0);
    chk("t3.step_idx", 0, u[0].step_idx, 7); chk("t3.step_idx", 1, u[1].step_idx, 7);

    // Abort halfway through step 1's window
    sv_mode = 1;
    snap(); go(3, 100);
    k = 0;
    while (!(u[0].step_idx == 1 && u[0].meas_en && u[0].n_ms_step == 50) && k < 5000) begin tick(); k++; end
    chk("t4.reach_mid_window", 0, k < 5000, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t4.busy", 0, u[0].busy, 0); chk("t4.meas_en", 0, u[0].meas_en, 0);
    chk("t4.jit_en", 0, u[0].jit_en, 0); chk("t4.aborted", 0, u[0].aborted, 1);
    chk("t4.step_idx", 0, u[0].step_idx, 1);
    wait_idle("t4", 5000);
    chk("t4.done_cnt", 0, u[0].n_done - b_dn[0], 0); chk("t4.aborted_cnt", 0, u[0].n_abt - b_ab[0], 1);
    chk("t4.step_done_cnt", 0, u[0].n_sd - b_sd[0], 1);

    // Table write and restart while busy are ignored
    sv_mode = 2;
    snap(); go(2, 10);
    repeat (5) tick();
    wr(0, 'hFFFF); go(8, 10);
    wait_idle("t5", 5000);
    lits("t5", 2, 1, 0);
    snap(); go(1, 3); wait_idle("t5b", 5000);
    chk("t5.entry0_kept", 0, u[0].sc[b_sd[0] % 256], 'h0000); chk("t5.entry0_kept", 1, u[1].sc[b_sd[1] % 256], 'h0000);

    // Zero window length behaves as one strobe
    snap(); go(2, 0); wait_idle("t6", 5000);
    lits("t6", 2, 1, 0);
    chk("t6.window_strobes", 0, u[0].n_ms - b_ms[0], 2); chk("t6.window_strobes", 1, u[1].n_ms - b_ms[1], 2);

    // Randomised sweeps with stray aborts, starts and writes
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(1) == 1) wr(int'($urandom_range(NS - 1)), int'($urandom_range(65535)));
      go(int'($urandom_range(10)), int'($urandom_range(6)));
      for (int c = 0; c < 2000 && (u[0].busy || u[1].busy); c++) begin
        abort = ($urandom_range(300) == 0);
        start = ($urandom_range(100) == 0);
        tbl_wr_en = ($urandom_range(40) == 0);
        tbl_wr_addr = IW'($urandom);
        tbl_wr_data = SW'($urandom);
        tick();
      end
      abort = 1'b0; start = 1'b0; tbl_wr_en = 1'b0;
      repeat (2) tick();
    end

    // Asynchronous reset while settling
    sv_mode = 1;
    snap(); go(2, 10);
    k = 0;
    while (!(u[0].busy && u[0].jit_en && !u[0].meas_en) && k < 100) begin tick(); k++; end
    chk("t8.reach_settle", 0, k < 100, 1);
    #1 reset = 1'b1;
    #1 zero_chk("t8");
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    lits("t8", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/impairment_sweep_ctrl.md
Name: impairment_sweep_ctrl

Overview:
Sequences the timing-jitter channel model through a programmed table of jitter scale settings for BER/lock sweeps.
- Holds each setting for a settle window, then a measurement window, counted in datapath sample strobes.
- Drives the jitter model's scale/enable and the downstream measurement block's clear/enable.
- Sits between the testbench/config host and the impairment + measurement chain.

Parameters:
NUM_STEPS, 8, table depth (number of jitter settings).
SCALE_W, 16, jitter scale width, unsigned Q0.16 fraction of sample period.
CNT_W, 24, width of settle/measure sample counters.
SETTLE_CYC, 1024, sample strobes discarded after each setting change.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-high.
start  in  1  single-cycle sweep start request.
abort  in  1  single-cycle sweep cancel.
step_count  in  $clog2(NUM_STEPS)+1  number of table entries to run.
meas_len  in  CNT_W  sample strobes per measurement window.
tbl_wr_en  in  1  table write strobe.
tbl_wr_addr  in  $clog2(NUM_STEPS)  table write address.
tbl_wr_data  in  SCALE_W  table write data.
sample_valid  in  1  datapath sample strobe.
jit_scale  out  SCALE_W  jitter scale to the impairment model.
jit_en  out  1  jitter model enable.
meas_clr  out  1  one-cycle clear to the measurement block.
meas_en  out  1  measurement window active.
step_idx  out  $clog2(NUM_STEPS)  current table index.
step_done  out  1  one-cycle pulse at end of each step's measurement.
busy  out  1  sweep in progress.
done  out  1  one-cycle pulse on normal sweep completion.
aborted  out  1  one-cycle pulse on abort completion.

Behaviour:
Reset:
- All outputs 0; FSM in IDLE; counters 0.
- Table contents are not reset (undefined until written).

Table:
- Write on tbl_wr_en only while busy=0.
- Writes while busy=1 are ignored.

Config sampling and limits:
- step_count and meas_len are sampled on the accepted start.
- step_count > NUM_STEPS clamps to NUM_STEPS.
- meas_len=0 is treated as 1.

FSM states: IDLE, LOAD, SETTLE, MEASURE, NEXT.

IDLE:
- busy=0.
- On start with step_count=0: done pulses next cycle; remain IDLE.
- On start with step_count≠0: go to LOAD, step_idx=0, busy=1 from next cycle.
- start while busy=1 is ignored.

LOAD (exactly 1 cycle):
- Register jit_scale<=table[step_idx], jit_en<=1.
- Load settle counter with SETTLE_CYC.
- Go to SETTLE, or to MEASURE directly if SETTLE_CYC=0.

SETTLE:
- Decrement the counter on each sample_valid.
- The sample_valid that brings the counter to 0 moves the FSM to MEASURE.

MEASURE entry and window:
- On entry, meas_clr is high for exactly the first cycle; meas_en=1 from that cycle on.
- Count sample_valid; the meas_len-th strobe is included in the window.
- meas_en drops the cycle after that strobe; go to NEXT.

NEXT (1 cycle):
- step_done pulses.
- If step_idx = count-1: jit_en<=0, jit_scale<=0, done pulses, busy<=0, go to IDLE.
- Otherwise step_idx++ and go to LOAD.

Timing rules:
- sample_valid in LOAD or NEXT is not counted.
- jit_scale is stable for the whole SETTLE+MEASURE of a step.

Abort:
- abort in any busy state: next cycle FSM=IDLE, jit_en=0, jit_scale=0, meas_en=0, busy=0, aborted pulses, step_idx holds its last value.
- No step_done or done is generated for the interrupted step.
- abort in IDLE has no effect.
- abort and start in the same IDLE cycle: abort wins, start is dropped.

Async reset mid-sweep:
- Immediate return to reset values; no done or aborted pulse.

Counter width:
- Counters saturate-free at CNT_W.
- meas_len and SETTLE_CYC must fit CNT_W (SETTLE_CYC ≤ 2^CNT_W−1, checked by elaboration assertion).

Test Plan:
- Table = {0x0000, 0x0A3D, 0x147B}, step_count=3, meas_len=100, SETTLE_CYC=16, sample_valid every 4th cycle -> jit_scale steps through the three values.
  - Each step: one meas_clr, meas_en high for exactly 100 strobes, step_done ×3.
  - done once; jit_en=0, jit_scale=0 after.
- step_count=0 start -> done pulses 1 cycle later; busy, jit_en, meas_en never assert.
- step_count=12 with NUM_STEPS=8 -> exactly 8 step_done pulses, step_idx ends at 7.
- abort during MEASURE of step 1 (50 of 100 strobes) -> next cycle: busy=0, meas_en=0, jit_en=0, aborted=1, no done; step_idx=1.
- tbl_wr_en to addr 0 with 0xFFFF while busy -> table unchanged; the next sweep shows original value.
  - Start asserted mid-sweep -> ignored, sweep length unchanged.
- meas_len=0, SETTLE_CYC=0 build -> LOAD→MEASURE directly; each step's window ends after 1 strobe.
  - reset asserted in SETTLE -> all outputs 0 immediately, no pulses.
